// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM high-time / period capture with APB register access
module pwm_capture #(
    parameter int W_DIV = 8,
    parameter int W_CTR = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        apbs_psel,
    input  logic        apbs_penable,
    input  logic        apbs_pwrite,
    input  logic [15:0] apbs_paddr,
    input  logic [31:0] apbs_pwdata,
    output logic [31:0] apbs_prdata,
    output logic        apbs_pready,
    output logic        apbs_pslverr,
    input  logic        padin,
    output logic        irq
);

    localparam logic [W_DIV-1:0] DIV_ONE  = W_DIV'(1);
    localparam logic [W_CTR-1:0] CTR_ONE  = W_CTR'(1);
    localparam logic [W_CTR-1:0] CTR_ZERO = '0;

    // Register file
    logic             en;
    logic             inv;
    logic             irq_en;
    logic             valid;
    logic             ovf;
    logic [W_DIV-1:0] div_reg;
    logic [W_CTR-1:0] high_reg;
    logic [W_CTR-1:0] period_reg;

    // Measurement state
    logic             sync1;
    logic             sync2;
    logic             lvl_prev;
    logic             armed;
    logic [W_DIV-1:0] presc;
    logic [W_CTR-1:0] high_cnt;
    logic [W_CTR-1:0] period_cnt;

    // Combinational helpers
    logic             lvl;
    logic             rise;
    logic             tick;
    logic             arm_evt;
    logic             cap_evt;
    logic             high_inc;
    logic             high_full;
    logic             period_full;
    logic             ovf_evt;
    logic [W_CTR-1:0] high_next;
    logic [W_CTR-1:0] period_next;
    logic             mapped;
    logic             wr_en;
    logic             wr_csr;
    logic             wr_div;

    assign lvl  = sync2 ^ inv;
    assign rise = lvl & ~lvl_prev;
    assign tick = en && (presc == DIV_ONE);

    assign arm_evt = en & rise & ~armed;
    assign cap_evt = en & rise & armed;

    // Counter values including this cycle's tick; a capture samples these so the
    // capture cycle itself is part of the measured period.
    assign high_inc    = tick & lvl;
    assign high_full   = &high_cnt;
    assign period_full = &period_cnt;
    assign high_next   = (high_inc && !high_full) ? high_cnt + CTR_ONE : high_cnt;
    assign period_next = (tick && !period_full) ? period_cnt + CTR_ONE : period_cnt;

    // An arming rise discards the tick, so only non-arming ticks can overflow.
    assign ovf_evt = ~arm_evt & ((high_inc & high_full) | (tick & period_full));

    assign mapped = (apbs_paddr[15:4] == 12'h000);
    assign wr_en  = apbs_psel & apbs_penable & apbs_pwrite & mapped;
    assign wr_csr = wr_en && (apbs_paddr[3:2] == 2'd0);
    assign wr_div = wr_en && (apbs_paddr[3:2] == 2'd1);

    assign apbs_pready  = 1'b1;
    assign apbs_pslverr = 1'b0;
    assign irq          = valid & irq_en;

    // Pad resynchroniser and edge-detect history; runs regardless of EN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            lvl_prev <= 1'b0;
        end else begin
            sync1    <= padin;
            sync2    <= sync1;
            lvl_prev <= lvl;
        end
    end

    // Prescaler, running counters and arm flag; all idle while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc      <= DIV_ONE;
            high_cnt   <= CTR_ZERO;
            period_cnt <= CTR_ZERO;
            armed      <= 1'b0;
        end else if (!en) begin
            presc      <= DIV_ONE;
            high_cnt   <= CTR_ZERO;
            period_cnt <= CTR_ZERO;
            armed      <= 1'b0;
        end else if (rise) begin
            presc      <= div_reg;
            high_cnt   <= CTR_ZERO;
            period_cnt <= CTR_ZERO;
            armed      <= 1'b1;
        end else begin
            presc      <= tick ? div_reg : presc - DIV_ONE;
            high_cnt   <= high_next;
            period_cnt <= period_next;
        end
    end

    // Captured results, overwritten on every capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_reg   <= CTR_ZERO;
            period_reg <= CTR_ZERO;
        end else if (cap_evt) begin
            high_reg   <= high_next;
            period_reg <= period_next;
        end
    end

    // Control bits and DIV from software writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en      <= 1'b0;
            inv     <= 1'b0;
            irq_en  <= 1'b0;
            div_reg <= DIV_ONE;
        end else begin
            if (wr_csr) begin
                en     <= apbs_pwdata[0];
                inv    <= apbs_pwdata[1];
                irq_en <= apbs_pwdata[2];
            end
            if (wr_div) begin
                div_reg <= apbs_pwdata[W_DIV-1:0];
            end
        end
    end

    // Sticky status flags; a hardware set wins over a same-cycle W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (cap_evt) begin
                valid <= 1'b1;
            end else if (wr_csr && apbs_pwdata[8]) begin
                valid <= 1'b0;
            end
            if (ovf_evt) begin
                ovf <= 1'b1;
            end else if (wr_csr && apbs_pwdata[9]) begin
                ovf <= 1'b0;
            end
        end
    end

    // Read mux; anything outside the four-word window reads zero.
    always_comb begin
        apbs_prdata = 32'h0;
        if (mapped) begin
            case (apbs_paddr[3:2])
                2'd0:    apbs_prdata = {22'h0, ovf, valid, 5'h0, irq_en, inv, en};
                2'd1:    apbs_prdata = {{(32-W_DIV){1'b0}}, div_reg};
                2'd2:    apbs_prdata = {{(32-W_CTR){1'b0}}, high_reg};
                default: apbs_prdata = {{(32-W_CTR){1'b0}}, period_reg};
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed vector bench for pwm_capture
module tb_pwm_capture;

    logic        clk;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        padin;
    logic        irq;

    int checks;
    int failures;

    pwm_capture #(.W_DIV(8), .W_CTR(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .apbs_psel    (psel),
        .apbs_penable (penable),
        .apbs_pwrite  (pwrite),
        .apbs_paddr   (paddr),
        .apbs_pwdata  (pwdata),
        .apbs_prdata  (prdata),
        .apbs_pready  (pready),
        .apbs_pslverr (pslverr),
        .padin        (padin),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    div;
        bit    inv;
        int    hi;
        int    lo;
        int    exp_high;
        int    exp_period;
    } vec_t;

    vec_t tbl[6];

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [15:0] addr, output logic [31:0] data);
        paddr = addr;
        #1;
        data = prdata;
    endtask

    task automatic apb_wr(input logic [15:0] addr, input logic [31:0] data);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = addr;
        pwdata  = data;
        cyc(1);
        penable = 1'b1;
        cyc(1);
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic do_reset();
        padin = 1'b0;
        rst   = 1'b1;
        cyc(2);
        rst   = 1'b0;
        cyc(1);
    endtask

    task automatic pwm(input int hi, input int lo);
        padin = 1'b1;
        cyc(hi);
        padin = 1'b0;
        cyc(lo);
    endtask

    initial begin
        logic [31:0] d;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        psel     = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = 16'h0;
        pwdata   = 32'h0;
        padin    = 1'b0;

        tbl[0] = '{"div1",     1, 1'b0,  30,  70, 30, 100};
        tbl[1] = '{"div4",     4, 1'b0, 120, 280, 30, 100};
        tbl[2] = '{"inv",      1, 1'b1,  30,  70, 70, 100};
        tbl[3] = '{"div2",     2, 1'b0,  10,  30,  5,  20};
        tbl[4] = '{"div3",     3, 1'b0,  30,  30, 10,  20};
        tbl[5] = '{"div0_256", 0, 1'b0, 512, 512,  2,   4};

        // Reset state and register map
        cyc(2);
        rst = 1'b0;
        cyc(1);
        rd(16'h0, d);  chk("rst_csr", d, 32'h0);
        rd(16'h4, d);  chk("rst_div", d, 32'h1);
        rd(16'h8, d);  chk("rst_high", d, 32'h0);
        rd(16'hC, d);  chk("rst_period", d, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("pready", {31'h0, pready}, 32'h1);
        chk("pslverr", {31'h0, pslverr}, 32'h0);
        apb_wr(16'h10, 32'hFFFF_FFFF);
        rd(16'h10, d); chk("unmapped_rd", d, 32'h0);
        rd(16'h0, d);  chk("unmapped_wr_csr", d, 32'h0);
        apb_wr(16'h4, 32'h1AB);
        rd(16'h4, d);  chk("div_rw", d, 32'hAB);

        // Table-driven waveforms: three pulses, first rise arms, later ones capture
        for (int i = 0; i < 6; i++) begin
            do_reset();
            apb_wr(16'h4, tbl[i].div);
            apb_wr(16'h0, {30'h0, tbl[i].inv, 1'b0});
            cyc(4);
            apb_wr(16'h0, {30'h0, tbl[i].inv, 1'b1});
            for (int k = 0; k < 3; k++) pwm(tbl[i].hi, tbl[i].lo);
            rd(16'h8, d); chk({tbl[i].name, "_high"}, d, tbl[i].exp_high);
            rd(16'hC, d); chk({tbl[i].name, "_period"}, d, tbl[i].exp_period);
            rd(16'h0, d); chk({tbl[i].name, "_csr"}, d, {22'h0, 2'b01, 6'h0, tbl[i].inv, 1'b1});
        end

        // Saturation and sticky overflow
        do_reset();
        apb_wr(16'h0, 32'h1);
        padin = 1'b1;
        cyc(3);
        cyc(70000);
        rd(16'h0, d);  chk("ovf_set", d, 32'h201);
        padin = 1'b0;
        cyc(20);
        padin = 1'b1;
        cyc(3);
        rd(16'h8, d);  chk("ovf_high", d, 32'hFFFF);
        rd(16'hC, d);  chk("ovf_period", d, 32'hFFFF);
        rd(16'h0, d);  chk("ovf_csr", d, 32'h301);
        apb_wr(16'h0, 32'h200);
        rd(16'h0, d);  chk("ovf_w1c", d, 32'h100);
        rd(16'h8, d);  chk("ovf_high_hold", d, 32'hFFFF);

        // IRQ and hardware-set priority over a same-cycle W1C
        do_reset();
        apb_wr(16'h0, 32'h5);
        pwm(30, 70);
        pwm(30, 70);
        chk("irq_first", {31'h0, irq}, 32'h1);
        rd(16'h0, d);  chk("irq_csr", d, 32'h105);
        padin = 1'b1;
        cyc(1);
        psel    = 1'b1;
        pwrite  = 1'b1;
        paddr   = 16'h0;
        pwdata  = 32'h105;
        cyc(1);
        penable = 1'b1;
        cyc(1);
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        rd(16'h0, d);  chk("w1c_vs_cap_csr", d, 32'h105);
        chk("w1c_vs_cap_irq", {31'h0, irq}, 32'h1);
        rd(16'h8, d);  chk("irq_high", d, 32'd30);
        rd(16'hC, d);  chk("irq_period", d, 32'd100);
        cyc(5);
        apb_wr(16'h0, 32'h105);
        rd(16'h0, d);  chk("w1c_quiet_csr", d, 32'h5);
        chk("w1c_quiet_irq", {31'h0, irq}, 32'h0);

        // EN cleared mid-period, then re-enabled
        do_reset();
        apb_wr(16'h0, 32'h1);
        for (int k = 0; k < 3; k++) pwm(30, 70);
        apb_wr(16'h0, 32'h100);
        pwm(20, 20);
        rd(16'h0, d);  chk("en_off_csr", d, 32'h0);
        rd(16'h8, d);  chk("en_off_high", d, 32'd30);
        rd(16'hC, d);  chk("en_off_period", d, 32'd100);
        apb_wr(16'h0, 32'h1);
        padin = 1'b1;
        cyc(3);
        rd(16'h0, d);  chk("rearm_no_cap", d, 32'h1);
        rd(16'h8, d);  chk("rearm_high", d, 32'd30);
        cyc(47);
        padin = 1'b0;
        cyc(150);
        padin = 1'b1;
        cyc(3);
        rd(16'h8, d);  chk("reen_high", d, 32'd50);
        rd(16'hC, d);  chk("reen_period", d, 32'd200);
        rd(16'h0, d);  chk("reen_csr", d, 32'h101);

        // Reset mid-capture aborts; first rise afterwards only arms
        padin = 1'b0;
        cyc(10);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        apb_wr(16'h0, 32'h1);
        padin = 1'b1;
        cyc(10);
        rd(16'h0, d);  chk("rst_abort_csr", d, 32'h1);
        rd(16'hC, d);  chk("rst_abort_period", d, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter W_DIV, default 8, prescaler divisor width.
REQ-002 SHALL have parameter W_CTR, default 16, high-time and period counter width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have APB slave ports apbs_psel/apbs_penable/apbs_pwrite  input  1 each; apbs_paddr  input  16; apbs_pwdata  input  32; apbs_prdata  output  32; apbs_pready  output  1; apbs_pslverr  output  1.
REQ-006 SHALL have port padin  input  1  asynchronous PWM input from pad.
REQ-007 SHALL have port irq  output  1  capture-valid interrupt.

Function
REQ-008 SHALL tie apbs_pready=1 and apbs_pslverr=0; writes take effect on psel&penable&pwrite; prdata combinational on paddr[3:2]; unmapped offsets read 0 and ignore writes.
REQ-009 SHALL map CSR at 0x0: bit0 EN (RW), bit1 INV (RW), bit2 IRQ_EN (RW), bit8 VALID (RO, W1C), bit9 OVF (RO, W1C).
REQ-010 SHALL map DIV at 0x4 (RW, bits W_DIV-1:0), HIGH at 0x8 (RO, bits W_CTR-1:0), PERIOD at 0xC (RO, bits W_CTR-1:0).
REQ-011 SHALL resynchronise padin through two flops, XOR with INV, then register once more for edge detect; rise = sync & !prev.
REQ-012 SHALL detect a padin rising edge (INV=0) on the 3rd clk edge after the input change; no capture path shall use unsynchronised padin.
REQ-013 SHALL run the prescaler only while EN=1: down-counter reloads from DIV when at 1 and asserts tick for that cycle; DIV=0 SHALL behave as 2^W_DIV; DIV=1 ticks every cycle.
REQ-014 SHALL increment PERIOD counter on each tick, and HIGH counter on each tick where the synchronised level is 1.
REQ-015 SHALL saturate each counter at all-ones; any tick that would overflow SHALL set OVF (sticky).
REQ-016 SHALL, on rise while EN=1 and armed=0: clear counters and prescaler (reload to DIV), set armed, no capture.
REQ-017 SHALL, on rise while armed=1: load HIGH and PERIOD from current counter values, set VALID, clear counters, reload prescaler.
REQ-018 SHALL give rise priority over a same-cycle tick: counters go to 0, tick increment discarded.
REQ-019 SHALL give hardware VALID/OVF set priority over a same-cycle W1C clear.
REQ-020 SHALL overwrite HIGH/PERIOD on every capture regardless of VALID (no hold-off).
REQ-021 SHALL, while EN=0, hold counters at 0, armed at 0, prescaler at 1; HIGH, PERIOD, VALID, OVF SHALL retain values.
REQ-022 SHALL drive irq = VALID & IRQ_EN, registered-free (combinational from flops).
REQ-023 SHALL ignore falling edges except that HIGH counter stops counting once level is 0.

Reset
REQ-024 SHALL on rst: CSR=0, DIV=1, HIGH=0, PERIOD=0, counters=0, prescaler=1, armed=0, synchroniser flops=0, irq=0.
REQ-025 SHALL treat rst asserted mid-capture as full abort; first rise after release and EN=1 only arms.

Verification
REQ-026 SHALL cover: DIV=1, EN=1, padin high 30 / low 70 clk, repeated -> after 2nd rise HIGH=30, PERIOD=100, VALID=1.
REQ-027 SHALL cover: DIV=4, same waveform scaled x4 (120/280 clk) -> HIGH=30, PERIOD=100.
REQ-028 SHALL cover: DIV=1, padin held high 70000 clk after arming -> HIGH=PERIOD=0xFFFF, OVF=1; write 0x200 to CSR -> OVF=0.
REQ-029 SHALL cover: INV=1, padin high 30 / low 70 -> HIGH=70, PERIOD=100.
REQ-030 SHALL cover: IRQ_EN=1, capture sets VALID -> irq=1; W1C 0x100 issued in same cycle as next capture -> VALID stays 1.
REQ-031 SHALL cover: EN cleared mid-period then set -> HIGH/PERIOD unchanged, first rise only arms, second rise captures correct values.
